// File: rtl/maxpool1_layer_pkg.sv
// ----------------------------------------------------------------------------
// maxpool1_layer_pkg
// Shared CNN parameters for the first conv/pool stage. conv1_layer and
// maxpool1_layer both take their defaults from here.
//   DATA_W  : conv sample width (signed two's complement)
//   IMG_W   : conv feature-map width and height (28-5+1), must be even
//   POOL_W  : pooled map width and height (IMG_W/2)
// ----------------------------------------------------------------------------
package maxpool1_layer_pkg;

    localparam int DATA_W = 12;
    localparam int IMG_W  = 24;
    localparam int POOL_W = IMG_W / 2;

    // Counter width for a 0..n-1 counter, never less than one bit
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxpool1_layer_channel.sv
// ----------------------------------------------------------------------------
// maxpool_channel
// One channel of the 2x2 max-pool with ReLU. The horizontal max of each
// pixel pair is formed on odd columns; on even rows it is parked in a line
// buffer, on odd rows it is combined with the parked value to finish the
// 2x2 window.
// Ports:
//   i_clk      : clock
//   i_rst_n    : asynchronous active-low reset
//   i_valid    : i_sample carries a valid pixel this cycle
//   i_col_odd  : current pixel sits in an odd column
//   i_row_odd  : current pixel sits in an odd row
//   i_addr     : line buffer entry (col/2)
//   i_sample   : signed conv sample
//   o_pool     : registered ReLU(2x2 max), holds between updates
// ----------------------------------------------------------------------------
module maxpool_channel
    import maxpool1_layer_pkg::*;
#(
    parameter int DATA_W = maxpool1_layer_pkg::DATA_W,
    parameter int IMG_W  = maxpool1_layer_pkg::IMG_W,
    localparam int POOL_W = IMG_W / 2,
    localparam int ADDR_W = cntWidth(IMG_W) - 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic                     i_col_odd,
    input  logic                     i_row_odd,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic signed [DATA_W-1:0] i_sample,
    output logic signed [DATA_W-1:0] o_pool
);

    logic signed [DATA_W-1:0] r_pair;
    logic signed [DATA_W-1:0] r_pool;
    logic signed [DATA_W-1:0] r_line [POOL_W];
    logic signed [DATA_W-1:0] w_hmax;
    logic signed [DATA_W-1:0] w_vmax;
    logic signed [DATA_W-1:0] w_relu;

    // Horizontal max of the pair, vertical max against the parked row, then
    // ReLU: a set sign bit means negative, which clamps to zero
    always_comb begin
        w_hmax = (r_pair > i_sample) ? r_pair : i_sample;
        w_vmax = (r_line[i_addr] > w_hmax) ? r_line[i_addr] : w_hmax;
        w_relu = w_vmax[DATA_W-1] ? '0 : w_vmax;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pair <= '0;
            r_pool <= '0;
        end else if (i_valid) begin
            if (!i_col_odd) begin
                r_pair <= i_sample;
            end else if (i_row_odd) begin
                r_pool <= w_relu;
            end
        end
    end

    // No reset: every entry is written on an even row before it is read
    always_ff @(posedge i_clk) begin
        if (i_valid && i_col_odd && !i_row_odd) begin
            r_line[i_addr] <= w_hmax;
        end
    end

    assign o_pool = r_pool;

endmodule

// File: rtl/maxpool1_layer.sv
// ----------------------------------------------------------------------------
// maxpool1_layer
// 2x2 / stride-2 max-pool with ReLU over the three conv1 channels. Shared
// raster counters advance only on valid pixels; each channel does its own
// compare and line buffering.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   valid_in               : conv_in_* carry one valid pixel this cycle
//   conv_in_1..3           : signed conv samples, raster order
//   pool_out_1..3          : pooled, non-negative results (held when idle)
//   valid_out              : pool_out_* updated this cycle (one-cycle pulse)
// ----------------------------------------------------------------------------
module maxpool1_layer
    import maxpool1_layer_pkg::*;
#(
    parameter int DATA_W = maxpool1_layer_pkg::DATA_W,
    parameter int IMG_W  = maxpool1_layer_pkg::IMG_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic signed [DATA_W-1:0] conv_in_1,
    input  logic signed [DATA_W-1:0] conv_in_2,
    input  logic signed [DATA_W-1:0] conv_in_3,
    output logic signed [DATA_W-1:0] pool_out_1,
    output logic signed [DATA_W-1:0] pool_out_2,
    output logic signed [DATA_W-1:0] pool_out_3,
    output logic                     valid_out
);

    localparam int CNT_W  = cntWidth(IMG_W);
    localparam int ADDR_W = CNT_W - 1;

    logic [CNT_W-1:0]  r_col;
    logic [CNT_W-1:0]  r_row;
    logic              r_valid_out;
    logic              w_col_odd;
    logic              w_row_odd;
    logic              w_col_last;
    logic              w_row_last;
    logic [ADDR_W-1:0] w_addr;

    assign w_col_odd  = r_col[0];
    assign w_row_odd  = r_row[0];
    assign w_col_last = (r_col == CNT_W'(IMG_W - 1));
    assign w_row_last = (r_row == CNT_W'(IMG_W - 1));
    assign w_addr     = r_col[CNT_W-1:1];

    // Raster position of the next valid pixel; a frame end rolls straight
    // into (0,0) of the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= valid_in && w_col_odd && w_row_odd;
            if (valid_in) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign valid_out = r_valid_out;

    maxpool_channel #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_ch1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_in),
        .i_col_odd(w_col_odd), .i_row_odd(w_row_odd), .i_addr(w_addr),
        .i_sample(conv_in_1), .o_pool(pool_out_1)
    );

    maxpool_channel #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_ch2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_in),
        .i_col_odd(w_col_odd), .i_row_odd(w_row_odd), .i_addr(w_addr),
        .i_sample(conv_in_2), .o_pool(pool_out_2)
    );

    maxpool_channel #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_ch3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_in),
        .i_col_odd(w_col_odd), .i_row_odd(w_row_odd), .i_addr(w_addr),
        .i_sample(conv_in_3), .o_pool(pool_out_3)
    );

endmodule

// File: tb/tb_maxpool1_layer.sv
// ----------------------------------------------------------------------------
// tb_maxpool1_layer
// Drives whole 24x24 frames into maxpool1_layer and compares the collected
// pooled outputs against a plain 2x2-max-plus-ReLU model of the frame.
// ----------------------------------------------------------------------------
module tb_maxpool1_layer;

    localparam int N   = 24;
    localparam int P   = N / 2;
    localparam int PIX = N * N;
    localparam int OUT = P * P;

    typedef logic [35:0] trip_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              valid_in;
    logic signed [11:0] conv_in_1, conv_in_2, conv_in_3;
    logic signed [11:0] pool_out_1, pool_out_2, pool_out_3;
    logic              valid_out;

    int    fr [3][PIX];
    trip_t got [$];
    trip_t expq [$];
    trip_t lastOut;
    bit    monEn = 1'b0;
    int    holdErr = 0;
    int    tests = 0;
    int    fails = 0;

    maxpool1_layer #(.DATA_W(12), .IMG_W(N)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .conv_in_1(conv_in_1), .conv_in_2(conv_in_2), .conv_in_3(conv_in_3),
        .pool_out_1(pool_out_1), .pool_out_2(pool_out_2), .pool_out_3(pool_out_3),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    // Collect every pulse and watch that outputs hold between pulses
    always @(negedge clk) begin
        if (monEn) begin
            if (!rst_n) begin
                lastOut = '0;
            end else if (valid_out) begin
                got.push_back({pool_out_1, pool_out_2, pool_out_3});
                lastOut = {pool_out_1, pool_out_2, pool_out_3};
            end else if ({pool_out_1, pool_out_2, pool_out_3} !== lastOut) begin
                holdErr++;
            end
        end
    end

    // Reference: for each pooled cell take the largest of its four pixels,
    // clamp negatives to zero
    task automatic buildExpected();
        int    m;
        trip_t t;
        expq.delete();
        for (int r = 0; r < P; r++) begin
            for (int c = 0; c < P; c++) begin
                for (int ch = 0; ch < 3; ch++) begin
                    m = fr[ch][(2*r)*N + 2*c];
                    if (fr[ch][(2*r)*N + 2*c + 1] > m) m = fr[ch][(2*r)*N + 2*c + 1];
                    if (fr[ch][(2*r+1)*N + 2*c] > m) m = fr[ch][(2*r+1)*N + 2*c];
                    if (fr[ch][(2*r+1)*N + 2*c + 1] > m) m = fr[ch][(2*r+1)*N + 2*c + 1];
                    if (m < 0) m = 0;
                    t[(2-ch)*12 +: 12] = 12'(m);
                end
                expq.push_back(t);
            end
        end
    endtask

    task automatic randomFrame();
        logic signed [11:0] s;
        for (int ch = 0; ch < 3; ch++) begin
            for (int i = 0; i < PIX; i++) begin
                s = 12'($urandom);
                fr[ch][i] = int'(s);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    task automatic drivePixel(input int idx);
        @(negedge clk);
        valid_in  = 1'b1;
        conv_in_1 = 12'(fr[0][idx]);
        conv_in_2 = 12'(fr[1][idx]);
        conv_in_3 = 12'(fr[2][idx]);
    endtask

    task automatic sendFrame(input bit gaps);
        for (int i = 0; i < PIX; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) idle(1);
            end
            drivePixel(i);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_in = 1'b0;
        conv_in_1 = '0; conv_in_2 = '0; conv_in_3 = '0;
        repeat (3) @(negedge clk);
        tests++;
        if (valid_out !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_valid: got %b want 0", valid_out);
        end
        tests++;
        if ({pool_out_1, pool_out_2, pool_out_3} !== 36'd0) begin
            fails++; $display("[TB] FAIL reset_out: got %h want 0", {pool_out_1, pool_out_2, pool_out_3});
        end
        rst_n = 1'b1;
        monEn = 1'b1;
        idle(2);
    endtask

    task automatic test_ramp();
        int bad;
        for (int ch = 0; ch < 3; ch++)
            for (int i = 0; i < PIX; i++) fr[ch][i] = i;
        got.delete();
        sendFrame(1'b0);
        idle(4);
        tests++;
        if (got.size() != OUT) begin
            fails++; $display("[TB] FAIL ramp_count: got %0d want %0d", got.size(), OUT);
        end else begin
            bad = 0;
            for (int r = 0; r < P; r++)
                for (int c = 0; c < P; c++)
                    if (got[r*P+c] !== {3{12'((2*r+1)*N + 2*c + 1)}}) bad++;
            if (bad != 0) begin
                fails++; $display("[TB] FAIL ramp_seq: got %0d wrong cells want 0", bad);
            end
            tests++;
            if (got[0] !== {3{12'd25}}) begin
                fails++; $display("[TB] FAIL ramp_first: got %h want %h", got[0], {3{12'd25}});
            end
            tests++;
            if (got[OUT-1] !== {3{12'd575}}) begin
                fails++; $display("[TB] FAIL ramp_last: got %h want %h", got[OUT-1], {3{12'd575}});
            end
        end
    endtask

    task automatic test_signs();
        int bad;
        randomFrame();
        for (int i = 0; i < PIX; i++) begin
            fr[0][i] = -5;
            fr[1][i] = 0;
        end
        fr[2][0] = -2048; fr[2][1] = -1; fr[2][N] = 7; fr[2][N+1] = -3;
        buildExpected();
        got.delete();
        sendFrame(1'b0);
        idle(4);
        tests++;
        if (got.size() != OUT) begin
            fails++; $display("[TB] FAIL signs_count: got %0d want %0d", got.size(), OUT);
        end else begin
            bad = 0;
            for (int i = 0; i < OUT; i++) if (got[i] !== expq[i]) bad++;
            if (bad != 0) begin
                fails++; $display("[TB] FAIL signs_seq: got %0d wrong cells want 0", bad);
            end
            tests++;
            if (got[0][11:0] !== 12'd7) begin
                fails++; $display("[TB] FAIL signs_ch3: got %0d want 7", got[0][11:0]);
            end
            tests++;
            bad = 0;
            for (int i = 0; i < OUT; i++) if (got[i][35:12] !== 24'd0) bad++;
            if (bad != 0) begin
                fails++; $display("[TB] FAIL signs_relu: got %0d nonzero cells on ch1/ch2 want 0", bad);
            end
        end
    endtask

    task automatic test_window_positions();
        int pos [4] = '{0, 1, N, N + 1};
        for (int p = 0; p < 4; p++) begin
            for (int ch = 0; ch < 3; ch++) begin
                for (int i = 0; i < PIX; i++) fr[ch][i] = 1;
                fr[ch][pos[p]] = 2047;
            end
            got.delete();
            sendFrame(1'b0);
            idle(4);
            tests++;
            if (got.size() != OUT) begin
                fails++; $display("[TB] FAIL pos%0d_count: got %0d want %0d", p, got.size(), OUT);
            end else if (got[0] !== {3{12'd2047}} || got[1] !== {3{12'd1}}) begin
                fails++; $display("[TB] FAIL pos%0d_max: got %h,%h want %h,%h",
                                  p, got[0], got[1], {3{12'd2047}}, {3{12'd1}});
            end
        end
    endtask

    task automatic test_gaps();
        trip_t cont [$];
        int bad;
        randomFrame();
        buildExpected();
        got.delete();
        sendFrame(1'b0);
        idle(4);
        cont = got;
        got.delete();
        holdErr = 0;
        sendFrame(1'b1);
        idle(4);
        tests++;
        if (cont.size() != OUT || got.size() != OUT) begin
            fails++; $display("[TB] FAIL gaps_count: got %0d/%0d want %0d", cont.size(), got.size(), OUT);
        end else begin
            bad = 0;
            for (int i = 0; i < OUT; i++) if (cont[i] !== expq[i]) bad++;
            if (bad != 0) begin
                fails++; $display("[TB] FAIL cont_seq: got %0d wrong cells want 0", bad);
            end
            tests++;
            bad = 0;
            for (int i = 0; i < OUT; i++) if (got[i] !== cont[i]) bad++;
            if (bad != 0) begin
                fails++; $display("[TB] FAIL gaps_seq: got %0d differing cells want 0", bad);
            end
        end
        tests++;
        if (holdErr != 0) begin
            fails++; $display("[TB] FAIL hold: got %0d changes while idle want 0", holdErr);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        got.delete();
        randomFrame();
        sendFrame(1'b0);
        randomFrame();
        buildExpected();
        sendFrame(1'b0);
        idle(4);
        tests++;
        if (got.size() != 2 * OUT) begin
            fails++; $display("[TB] FAIL b2b_count: got %0d want %0d", got.size(), 2 * OUT);
        end else begin
            bad = 0;
            for (int i = 0; i < OUT; i++) if (got[OUT+i] !== expq[i]) bad++;
            if (bad != 0) begin
                fails++; $display("[TB] FAIL b2b_seq: got %0d wrong cells want 0", bad);
            end
        end
    endtask

    task automatic test_mid_reset();
        int bad;
        randomFrame();
        for (int i = 0; i <= 9 * N + 13; i++) drivePixel(i);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        valid_in = 1'b0;
        #1;
        tests++;
        if (valid_out !== 1'b0 || {pool_out_1, pool_out_2, pool_out_3} !== 36'd0) begin
            fails++; $display("[TB] FAIL async_reset: got valid %b out %h want 0/0",
                              valid_out, {pool_out_1, pool_out_2, pool_out_3});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        randomFrame();
        buildExpected();
        sendFrame(1'b0);
        idle(4);
        tests++;
        if (got.size() != OUT) begin
            fails++; $display("[TB] FAIL mid_reset_count: got %0d want %0d", got.size(), OUT);
        end else begin
            bad = 0;
            for (int i = 0; i < OUT; i++) if (got[i] !== expq[i]) bad++;
            if (bad != 0) begin
                fails++; $display("[TB] FAIL mid_reset_seq: got %0d wrong cells want 0", bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_signs();
        test_window_positions();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
